// File: rtl/dmem_sequencer.sv
// Byte-serial sequencer for the 1024x8 data RAM: turns 64-bit loads/stores into
// eight little-endian byte cycles and lets the program loader use idle cycles.
module dmem_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // Memory-stage port: m_req_i and operands stay stable until m_done_o pulses.
    input  logic              m_req_i,
    input  logic              m_we_i,
    input  logic [63:0]       m_addr_i,
    input  logic [63:0]       m_wdata_i,
    output logic              m_stall_o,
    output logic              m_done_o,
    output logic              m_err_o,
    output logic [63:0]       m_rdata_o,
    // Loader port: a request is performed in the cycle l_gnt_o is high, else held.
    input  logic              l_req_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [7:0]        l_data_i,
    output logic              l_gnt_o,
    // RAM port: read data returns one cycle after the address is presented.
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i,
    // Debug view of the FSM: 0=IDLE, 1=READ, 2=WRITE, 3=DONE.
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Highest legal base address: the last byte of the word must still be inside the RAM.
    localparam logic [63:0] LAST_OK = 64'(DEPTH - 8);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_base;
    logic [63:0]         r_wdata;
    logic [63:0]         r_asm;
    logic                r_err;
    logic                r_done;
    logic                r_m_err;
    logic [63:0]         r_rdata;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [7:0]          r_ram_wdata;

    logic                w_addr_bad;
    logic                w_gnt;
    logic                w_m_wr;
    logic                w_m_rd_addr;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [63:0]         w_asm_next;

    assign w_addr_bad  = (m_addr_i > LAST_OK);
    assign w_gnt       = (r_state == S_IDLE) & ~m_req_i & l_req_i;
    assign w_m_wr      = (r_state == S_WRITE);
    assign w_m_rd_addr = (r_state == S_READ) & ~r_cnt[3];
    assign w_cur_addr  = r_base + {{(ADDR_W-3){1'b0}}, r_cnt[2:0]};
    assign w_asm_next  = {ram_rdata_i, r_asm[63:8]};

    assign m_stall_o   = m_req_i & ~m_done_o;
    assign m_done_o    = r_done;
    assign m_err_o     = r_m_err;
    assign m_rdata_o   = r_rdata;
    assign l_gnt_o     = w_gnt;
    assign dbg_state_o = r_state;

    // RAM address/data hold their last driven value whenever neither port is active.
    always_comb begin
        ram_we_o    = w_m_wr | w_gnt;
        ram_addr_o  = r_ram_addr;
        ram_wdata_o = r_ram_wdata;
        if (w_m_wr) begin
            ram_addr_o  = w_cur_addr;
            ram_wdata_o = r_wdata[7:0];
        end else if (w_m_rd_addr) begin
            ram_addr_o  = w_cur_addr;
        end else if (w_gnt) begin
            ram_addr_o  = l_addr_i;
            ram_wdata_o = l_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_base      <= '0;
            r_wdata     <= 64'd0;
            r_asm       <= 64'd0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_m_err     <= 1'b0;
            r_rdata     <= 64'd0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 8'd0;
        end else begin
            r_done      <= 1'b0;
            r_m_err     <= 1'b0;
            r_ram_addr  <= ram_addr_o;
            r_ram_wdata <= ram_wdata_o;
            case (r_state)
                S_IDLE: begin
                    if (m_req_i) begin
                        r_base  <= m_addr_i[ADDR_W-1:0];
                        r_wdata <= m_wdata_i;
                        r_cnt   <= 4'd0;
                        r_err   <= w_addr_bad;
                        if (w_addr_bad) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_m_err <= 1'b1;
                        end else if (m_we_i) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    // Low byte goes out first; shifting keeps the next byte at [7:0].
                    r_wdata <= {8'd0, r_wdata[63:8]};
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_m_err <= r_err;
                    end
                end
                S_READ: begin
                    // Data for the address of cycle cnt-1 arrives in cycle cnt.
                    if (r_cnt != 4'd0) begin
                        r_asm <= w_asm_next;
                    end
                    if (r_cnt == 4'd8) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_m_err <= r_err;
                        r_rdata <= w_asm_next;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Randomized self-checking bench for dmem_sequencer against a byte-array memory
// model with directed reset, boundary, arbitration and back-to-back scenarios.
module tb_dmem_sequencer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam logic [63:0] LAST_OK = 64'd1016;
    localparam logic [1:0] DBG_IDLE = 2'd0;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              m_req_i = 1'b0;
    logic              m_we_i = 1'b0;
    logic [63:0]       m_addr_i = 64'd0;
    logic [63:0]       m_wdata_i = 64'd0;
    logic              m_stall_o;
    logic              m_done_o;
    logic              m_err_o;
    logic [63:0]       m_rdata_o;
    logic              l_req_i = 1'b0;
    logic [ADDR_W-1:0] l_addr_i = '0;
    logic [7:0]        l_data_i = 8'd0;
    logic              l_gnt_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [7:0]        ram_wdata_o;
    logic [7:0]        ram_rdata_i;
    logic [1:0]        dbg_state_o;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    bit          mem_init = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          we_cnt = 0;
    logic [63:0] exp_rdata = 64'd0;
    logic [63:0] exp_q [$];

    dmem_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .m_req_i     (m_req_i),
        .m_we_i      (m_we_i),
        .m_addr_i    (m_addr_i),
        .m_wdata_i   (m_wdata_i),
        .m_stall_o   (m_stall_o),
        .m_done_o    (m_done_o),
        .m_err_o     (m_err_o),
        .m_rdata_o   (m_rdata_o),
        .l_req_i     (l_req_i),
        .l_addr_i    (l_addr_i),
        .l_data_i    (l_data_i),
        .l_gnt_o     (l_gnt_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and synchronous RAM with one-cycle read latency.
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29 + 7) % 256);
    endfunction

    always @(posedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else if (ram_we_o) begin
            mem[ram_addr_o] <= ram_wdata_o;
        end
        ram_rdata_i <= mem[ram_addr_o];
        if (ram_we_o) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input int base);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[base + i];
        return v;
    endfunction

    // Caller is at a negedge of an IDLE cycle (or of a DONE cycle when b2b=1).
    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input bit b2b, input bit hold_after);
        bit          bad;
        int          lat;
        int          done_k;
        int          we_before;
        int          base;
        logic [63:0] sh;
        bad  = (addr > LAST_OK);
        lat  = bad ? 1 : (we ? 9 : 10);
        base = int'(addr[ADDR_W-1:0]);
        m_req_i = 1'b1;
        m_we_i = we;
        m_addr_i = addr;
        m_wdata_i = wdata;
        if (b2b) begin
            #1;
            check("stall_in_done", 64'(m_stall_o), 64'd0);
            @(negedge clk_i);
        end
        if (!we && !bad) exp_q.push_back(model_load(base));
        we_before = we_cnt;
        #1;
        check("stall_accept", 64'(m_stall_o), 64'd1);
        check("gnt_accept", 64'(l_gnt_o), 64'd0);
        done_k = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_i);
            if (m_done_o) begin
                done_k = k;
                break;
            end
            check("stall_busy", 64'(m_stall_o), 64'd1);
            check("gnt_busy", 64'(l_gnt_o), 64'd0);
        end
        check("latency", 64'(done_k), 64'(lat));
        check("stall_done", 64'(m_stall_o), 64'd0);
        check("err", 64'(m_err_o), 64'(bad));
        if (!we && !bad && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
        check("rdata", m_rdata_o, exp_rdata);
        check("ram_writes", 64'(we_cnt - we_before), (we && !bad) ? 64'd8 : 64'd0);
        if (we && !bad) begin
            sh = wdata;
            for (int i = 0; i < 8; i++) begin
                ref_mem[base + i] = sh[7:0];
                sh = sh >> 8;
            end
        end
        if (!hold_after) m_req_i = 1'b0;
    endtask

    // Caller is at a negedge of an IDLE cycle with m_req_i low.
    task automatic loader_write(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        l_req_i = 1'b1;
        l_addr_i = addr;
        l_data_i = data;
        #1;
        check("ldr_gnt", 64'(l_gnt_o), 64'd1);
        check("ldr_we", 64'(ram_we_o), 64'd1);
        check("ldr_addr", 64'(ram_addr_o), 64'(addr));
        ref_mem[addr] = data;
        @(negedge clk_i);
        l_req_i = 1'b0;
    endtask

    initial begin
        logic [63:0] word;
        logic [63:0] a;
        int          mism;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);

        // Power-on reset.
        repeat (3) @(negedge clk_i);
        check("rst_state", 64'(dbg_state_o), 64'(DBG_IDLE));
        check("rst_done", 64'(m_done_o), 64'd0);
        check("rst_err", 64'(m_err_o), 64'd0);
        check("rst_rdata", m_rdata_o, 64'd0);
        check("rst_we", 64'(ram_we_o), 64'd0);
        check("rst_addr", 64'(ram_addr_o), 64'd0);
        check("rst_wdata", 64'(ram_wdata_o), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Store then load the reference word.
        word = 64'h1122334455667788;
        issue(1'b1, 64'h10, word, 1'b0, 1'b0);
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) check("store_byte", 64'(mem[16 + i]), 64'(word[8*i +: 8]));
        issue(1'b0, 64'h10, 64'd0, 1'b0, 1'b0);
        check("load_word", m_rdata_o, 64'h1122334455667788);
        @(negedge clk_i);

        // Range boundary.
        issue(1'b0, 64'd1016, 64'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        issue(1'b0, 64'd1017, 64'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        issue(1'b1, 64'd1017, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        @(negedge clk_i);
        issue(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, 1'b0);
        @(negedge clk_i);

        // Simultaneous loader and memory-stage requests.
        l_req_i = 1'b1;
        l_addr_i = 10'd5;
        l_data_i = 8'hAB;
        issue(1'b0, 64'h40, 64'd0, 1'b0, 1'b0);
        #1;
        check("arb_gnt_done", 64'(l_gnt_o), 64'd0);
        @(negedge clk_i);
        check("arb_gnt_idle", 64'(l_gnt_o), 64'd1);
        check("arb_we", 64'(ram_we_o), 64'd1);
        check("arb_addr", 64'(ram_addr_o), 64'd5);
        ref_mem[5] = 8'hAB;
        @(negedge clk_i);
        l_req_i = 1'b0;
        check("arb_ram5", 64'(mem[5]), 64'hAB);
        issue(1'b0, 64'h0, 64'd0, 1'b0, 1'b0);
        @(negedge clk_i);

        // Back-to-back loads.
        issue(1'b1, 64'h28, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
        @(negedge clk_i);
        issue(1'b0, 64'h20, 64'd0, 1'b0, 1'b1);
        issue(1'b0, 64'h28, 64'd0, 1'b1, 1'b0);
        check("b2b_second", m_rdata_o, 64'hCAFE_F00D_1234_5678);
        @(negedge clk_i);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1: loader_write(10'($urandom_range(0, DEPTH - 1)), 8'($urandom));
                2: begin
                    a = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1017, 1023))
                                                    : {32'($urandom), 32'($urandom)};
                    issue(1'($urandom), a, {32'($urandom), 32'($urandom)}, 1'b0, 1'b0);
                end
                default: begin
                    a = 64'($urandom_range(0, 1016));
                    issue(1'($urandom), a, {32'($urandom), 32'($urandom)}, 1'b0, 1'b0);
                end
            endcase
            repeat (1 + $urandom_range(0, 2)) @(negedge clk_i);
        end

        // Reset in the middle of a store: four bytes reach the RAM first.
        word = 64'h0102_0304_A5B6_C7D8;
        m_req_i = 1'b1;
        m_we_i = 1'b1;
        m_addr_i = 64'h100;
        m_wdata_i = word;
        repeat (4) @(negedge clk_i);
        rst_n_i = 1'b0;
        m_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("mid_rst_state", 64'(dbg_state_o), 64'(DBG_IDLE));
        check("mid_rst_done", 64'(m_done_o), 64'd0);
        check("mid_rst_rdata", m_rdata_o, 64'd0);
        check("mid_rst_we", 64'(ram_we_o), 64'd0);
        check("mid_rst_stall", 64'(m_stall_o), 64'd0);
        rst_n_i = 1'b1;
        exp_rdata = 64'd0;
        for (int i = 0; i < 4; i++) ref_mem[256 + i] = word[8*i +: 8];
        for (int i = 0; i < 8; i++) check("mid_rst_ram", 64'(mem[256 + i]), 64'(ref_mem[256 + i]));
        @(negedge clk_i);
        issue(1'b0, 64'h100, 64'd0, 1'b0, 1'b0);
        @(negedge clk_i);

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("final_ram", 64'(mism), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_sequencer.md
Name: dmem_sequencer

Overview:
- Sequencer and arbiter for the byte-wide data RAM (1024 x 8) behind the memory-access stage.
- Turns each 64-bit load/store from the pipeline into eight byte-serial RAM cycles, little-endian.
- Range-checks the address and stalls the pipeline until the access completes.
- Shares the RAM with a byte-wide program loader port at lower priority.

Parameters:
- ADDR_W, 10, RAM address width.
- DEPTH, 1024, RAM size in bytes; must equal 2**ADDR_W.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- m_req_i  in  1  memory-stage request; held stable with operands until m_done_o.
- m_we_i  in  1  1 = store (rmmovq/pushq/call), 0 = load (mrmovq/popq/ret).
- m_addr_i  in  64  byte address.
- m_wdata_i  in  64  store data.
- m_stall_o  out  1  stall the pipeline = m_req_i & ~m_done_o (combinational).
- m_done_o  out  1  one-cycle completion pulse.
- m_err_o  out  1  valid with m_done_o; 1 = address out of range (maps to STAT_ADR).
- m_rdata_o  out  64  load result; held until the next load completes.
- l_req_i  in  1  loader byte-write request.
- l_addr_i  in  ADDR_W  loader byte address.
- l_data_i  in  8  loader byte.
- l_gnt_o  out  1  loader write performed this cycle (combinational).
- ram_addr_o  out  ADDR_W  RAM address.
- ram_we_o  out  1  RAM write enable.
- ram_wdata_o  out  8  RAM write byte.
- ram_rdata_i  in  8  RAM read byte; 1-cycle latency (data for the address at edge N appears after edge N).

Behaviour:
- States: IDLE, READ, WRITE, DONE. 4-bit byte counter cnt. Latched base address, write data, error flag.
- Reset (rst_n_i low at a clock edge): state=IDLE, cnt=0, m_rdata_o=0, m_done_o=0, m_err_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0. RAM contents are untouched. A store aborted by reset leaves its partially written bytes in RAM.
- IDLE, m_req_i=1:
  - Latch operands; cnt=0.
  - If m_addr_i > DEPTH-8 (unsigned 64-bit compare), go to DONE with err=1; no RAM access.
  - Otherwise go to WRITE if m_we_i=1, else READ.
- WRITE: per cycle ram_we_o=1, ram_addr_o=base+cnt, ram_wdata_o=wdata[8*cnt+7:8*cnt]. After cnt=7, go to DONE.
- READ:
  - Cycles cnt=0..7: ram_addr_o=base+cnt, ram_we_o=0.
  - On cycles cnt=1..8, capture ram_rdata_i into byte cnt-1 of a shift/assembly register.
  - After cnt=8, go to DONE and load the assembled word into m_rdata_o.
- DONE: m_done_o=1 for exactly one cycle; m_err_o=err; next state is IDLE. m_req_i is ignored in DONE.
- Latency from the IDLE cycle that accepts the request:
  - store: m_done_o in the 9th following cycle.
  - load: m_done_o in the 10th following cycle.
  - error: m_done_o in the next cycle.
- m_rdata_o is unchanged by stores and errored accesses.
- Loader arbitration:
  - l_gnt_o = (state==IDLE) & ~m_req_i & l_req_i.
  - When granted, that cycle drives ram_we_o=1, ram_addr_o=l_addr_i, ram_wdata_o=l_data_i.
  - The memory stage always wins a simultaneous request; an ungranted loader holds its request.
- Back-to-back: a new m_req_i is accepted in the IDLE cycle that follows DONE. Minimum one idle cycle between accesses, which gives the loader a window.
- Address wrap: never occurs, because the range check guarantees base+7 ≤ DEPTH-1. Exact boundary: addr=DEPTH-8 is legal; addr=DEPTH-7 errors.
- RAM outputs when neither port is active: ram_we_o=0, ram_addr_o holds its last value.

Test Plan:
- Reset: hold rst_n_i=0 for 2 cycles mid-WRITE -> state IDLE, m_done_o=0, m_rdata_o=0; bytes already written remain in RAM.
- Store then load:
  - Store 0x1122334455667788 to addr 0x10 -> RAM[0x10]=0x88 … RAM[0x17]=0x11; m_done_o 9 cycles after accept.
  - Load addr 0x10 -> m_rdata_o=0x1122334455667788, m_err_o=0, m_done_o 10 cycles after accept.
- Boundary:
  - Load addr 1016 -> m_err_o=0.
  - Load addr 1017 -> m_done_o next cycle with m_err_o=1, no ram_we_o, m_rdata_o unchanged.
  - Load addr 0xFFFF_FFFF_FFFF_FFF8 -> m_err_o=1.
- Arbitration: assert l_req_i (addr 5, data 0xAB) and m_req_i in the same IDLE cycle -> l_gnt_o=0 until the m access completes; l_gnt_o=1 in the IDLE cycle after DONE; RAM[5]=0xAB.
- Stall: during any access -> m_stall_o=1 every cycle from acceptance through the cycle before DONE, and 0 in the DONE cycle.
- Back-to-back loads: two loads to 0x20 and 0x28 -> second is accepted exactly one cycle after the first m_done_o; both values correct.
